timer0_clk_ctrl: RTL and testbench
==================================

// Module: timer0_clk_ctrl
// PURPOSE
//  Clock-enable scheduler and counter sequencer for Timer/Counter0 of the ATMega32A model.
//  Generates single-cycle count enables from sysClock using a shared 10-bit prescaler.
//  Sources: clk/1, /8, /64, /256, /1024, or external T0 edge. Reg clock is never divided.
//  Advances TCNT0 on each enable and raises TOV0/OCF0 toward the interrupt logic.
// PARAMETERS
//  PRESC_W   10    prescaler width; must be >= 10 to reach clk/1024
//  SYNC_STG  2     T0 pin synchronizer flops ahead of edge-detect flop
// PORTS
//  clk         in   1        system clock; all state changes on rising edge
//  rst_n       in   1        reset, synchronous, active-low
//  cs          in   3        CS0[2:0] clock select, from TCCR0
//  psr_clr     in   1        PSR10 pulse; clears prescaler
//  t0_pin      in   1        raw external T0 input, asynchronous
//  tcnt_wr     in   1        CPU write strobe for TCNT0
//  tcnt_wdata  in   8        CPU write data for TCNT0
//  ocr         in   8        OCR0 compare value
//  flag_clr    in   2        [0]=clear TOV0, [1]=clear OCF0 (write-1-to-clear)
//  tick        out  1        registered 1-cycle pulse, high in cycle after each count
//  tcnt        out  8        TCNT0 value
//  tov         out  1        TOV0 overflow flag
//  ocf         out  1        OCF0 compare-match flag
//  presc       out  PRESC_W  prescaler value, for debug/visibility
// BEHAVIOUR
//  Reset (rst_n=0 at edge): presc, tcnt, tick, tov, ocf, sync/edge flops -> 0.
//  Prescaler:
//    - presc increments every clk regardless of cs and wraps at all-ones.
//    - psr_clr=1 -> presc=0 next edge (wins over increment).
//  Enable en (combinational, from current cs and presc/edge):
//    - 000: never
//    - 001: every cycle
//    - 010: presc[2:0]==7
//    - 011: presc[5:0]==63
//    - 100: presc[7:0]==255
//    - 101: presc[9:0]==1023
//    - 110: T0 falling edge
//    - 111: T0 rising edge
//    - en is suppressed in any cycle where psr_clr=1.
//  External path:
//    - SYNC_STG flops, then one history flop.
//    - Edge is seen 3 clks after the pin change (SYNC_STG=2), and en pulses for exactly 1 clk.
//  cs change:
//    - New cs is used from the cycle it is presented.
//    - Prescaler is not reset; no extra or double en.
//    - Edge history keeps sampling for all cs values, so switching to 110/111 creates no false edge.
//  Counter update (same edge), by priority:
//    - tcnt_wr: tcnt=tcnt_wdata; en in that cycle is dropped; compare is blocked on the next en.
//    - en: tcnt=tcnt+1 mod 256.
//    - tcnt value 8'hFF with en -> tcnt=0 and tov set.
//  Compare:
//    - On en, if tcnt+1 == ocr (post-increment value) and compare is not blocked, ocf is set.
//    - ocr==0 matches on wrap.
//  Flags:
//    - Set takes priority over a simultaneous flag_clr.
//    - Flags hold until cleared or reset.
//  tick:
//    - Registered copy of effective en (0 when dropped by tcnt_wr).
//    - Aligned with the updated tcnt.
//  Reset mid-count clears everything; counting resumes on the first qualifying en after release.
// TESTING
//  1. cs=001, ocr=5, 300 clks from reset:
//     tick every clk; tcnt=5 with ocf=1 on the 5th tick; tov=1 on the 256th tick, tcnt=0.
//  2. cs=101, psr_clr at cycle 500:
//     first tick exactly 1024 clks after psr_clr; no tick at presc 1023 before the clear.
//  3. cs=111, toggle t0_pin every 7 clks:
//     one tick per rising edge, 3 clks after it; cs=110 ticks only on falling edges.
//  4. tcnt_wr=1, wdata=8'hFE, same cycle as en; ocr=8'hFF:
//     tcnt=FE, no tick; next en -> FF, ocf stays 0 (blocked); next en -> 00, tov=1.
//  5. flag_clr=2'b01 in same cycle as overflow -> tov=1.
//     flag_clr=2'b01 one cycle later -> tov=0.
//  6. cs 011->100 mid-run at presc=63, then rst_n=0 for 1 clk:
//     no tick at 63 (new cs used); after reset all outputs 0 and presc restarts at 0.

Source files
------------

// File: rtl/timer0_clk_ctrl_if.sv
// Register-side signal bundle for the Timer/Counter0 clock controller.
// The slave modport is the timer; the master modport is the CPU/register side.
interface timer0_clk_ctrl_if #(
    parameter int PRESC_W = 10
);
    logic [2:0]         cs;
    logic               psr_clr;
    logic               t0_pin;
    logic               tcnt_wr;
    logic [7:0]         tcnt_wdata;
    logic [7:0]         ocr;
    logic [1:0]         flag_clr;
    logic               tick;
    logic [7:0]         tcnt;
    logic               tov;
    logic               ocf;
    logic [PRESC_W-1:0] presc;

    modport master (
        output cs, psr_clr, t0_pin, tcnt_wr, tcnt_wdata, ocr, flag_clr,
        input  tick, tcnt, tov, ocf, presc
    );

    modport slave (
        input  cs, psr_clr, t0_pin, tcnt_wr, tcnt_wdata, ocr, flag_clr,
        output tick, tcnt, tov, ocf, presc
    );
endinterface

// File: rtl/timer0_clk_ctrl.sv
// Timer/Counter0 clock-enable scheduler: shared prescaler, T0 edge detector,
// TCNT0 sequencer with TOV0/OCF0 flags.
module timer0_clk_ctrl #(
    parameter int PRESC_W  = 10,
    parameter int SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timer0_clk_ctrl_if.slave      bus
);

    logic [PRESC_W-1:0]  presc_q;
    logic [SYNC_STG-1:0] sync_q;
    logic                hist_q;
    logic [7:0]          tcnt_q;
    logic                tick_q;
    logic                tov_q;
    logic                ocf_q;
    logic                cmp_blk_q;

    logic                t0_now;
    logic                en_raw;
    logic                en;
    logic                cnt_en;
    logic [7:0]          tcnt_inc;
    logic                tov_set;
    logic                ocf_set;

    assign t0_now   = sync_q[SYNC_STG-1];
    assign tcnt_inc = tcnt_q + 8'd1;

    always_comb begin
        en_raw = 1'b0;
        case (bus.cs)
            3'b001:  en_raw = 1'b1;
            3'b010:  en_raw = &presc_q[2:0];
            3'b011:  en_raw = &presc_q[5:0];
            3'b100:  en_raw = &presc_q[7:0];
            3'b101:  en_raw = &presc_q[9:0];
            3'b110:  en_raw = hist_q & ~t0_now;
            3'b111:  en_raw = ~hist_q & t0_now;
            default: en_raw = 1'b0;
        endcase
        en = en_raw & ~bus.psr_clr;
    end

    // A CPU write to TCNT0 swallows a coincident count and arms the compare blocker
    assign cnt_en  = en & ~bus.tcnt_wr;
    assign tov_set = cnt_en & (tcnt_q == 8'hFF);
    assign ocf_set = cnt_en & ~cmp_blk_q & (tcnt_inc == bus.ocr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            tcnt_q    <= 8'd0;
            tick_q    <= 1'b0;
            tov_q     <= 1'b0;
            ocf_q     <= 1'b0;
            cmp_blk_q <= 1'b0;
        end else begin
            presc_q <= bus.psr_clr ? '0 : presc_q + PRESC_W'(1);
            sync_q  <= {sync_q[SYNC_STG-2:0], bus.t0_pin};
            hist_q  <= t0_now;
            tick_q  <= cnt_en;
            if (bus.tcnt_wr) begin
                tcnt_q    <= bus.tcnt_wdata;
                cmp_blk_q <= 1'b1;
            end else if (en) begin
                tcnt_q    <= tcnt_inc;
                cmp_blk_q <= 1'b0;
            end
            // Setting a flag beats a simultaneous write-1-to-clear
            tov_q <= tov_set | (tov_q & ~bus.flag_clr[0]);
            ocf_q <= ocf_set | (ocf_q & ~bus.flag_clr[1]);
        end
    end

    assign bus.tick  = tick_q;
    assign bus.tcnt  = tcnt_q;
    assign bus.tov   = tov_q;
    assign bus.ocf   = ocf_q;
    assign bus.presc = presc_q;

endmodule

// File: tb/tb_timer0_clk_ctrl.sv
// Directed bench for timer0_clk_ctrl with an integer-level reference model
// checked against the DUT on every falling edge.
module tb_timer0_clk_ctrl;

    logic clk;
    logic rst_n;

    timer0_clk_ctrl_if #(.PRESC_W(10)) bus ();

    timer0_clk_ctrl #(.PRESC_W(10), .SYNC_STG(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state: plain integers, divisors and a pin sample history
    int m_presc, m_tcnt;
    bit m_tick, m_tov, m_ocf, m_blk, m_valid;
    bit pin_d1, pin_d2, pin_d3;

    function automatic int divisor(input logic [2:0] sel);
        case (sel)
            3'd2:    return 8;
            3'd3:    return 64;
            3'd4:    return 256;
            default: return 1024;
        endcase
    endfunction

    always @(posedge clk) begin
        bit en, tov_set, ocf_set;
        if (!rst_n) begin
            m_presc = 0; m_tcnt = 0; m_tick = 0; m_tov = 0; m_ocf = 0; m_blk = 0;
            pin_d1 = 0; pin_d2 = 0; pin_d3 = 0;
        end else begin
            en = 0;
            tov_set = 0;
            ocf_set = 0;
            case (bus.cs)
                3'd1:                   en = 1;
                3'd2, 3'd3, 3'd4, 3'd5: en = ((m_presc + 1) % divisor(bus.cs)) == 0;
                3'd6:                   en = (pin_d3 == 1) && (pin_d2 == 0);
                3'd7:                   en = (pin_d3 == 0) && (pin_d2 == 1);
                default:                en = 0;
            endcase
            if (bus.psr_clr) en = 0;
            if (bus.tcnt_wr) begin
                m_tcnt = bus.tcnt_wdata;
                m_blk  = 1;
            end else if (en) begin
                m_tcnt = (m_tcnt + 1) % 256;
                if (m_tcnt == 0) tov_set = 1;
                if (m_tcnt == int'(bus.ocr) && !m_blk) ocf_set = 1;
                m_blk = 0;
            end
            m_tick  = en && !bus.tcnt_wr;
            m_tov   = tov_set || (m_tov && !bus.flag_clr[0]);
            m_ocf   = ocf_set || (m_ocf && !bus.flag_clr[1]);
            m_presc = bus.psr_clr ? 0 : (m_presc + 1) % 1024;
            pin_d3  = pin_d2;
            pin_d2  = pin_d1;
            pin_d1  = bus.t0_pin;
        end
        m_valid = 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model tick",  int'(bus.tick),  int'(m_tick));
            checkOutput("model tcnt",  int'(bus.tcnt),  m_tcnt);
            checkOutput("model tov",   int'(bus.tov),   int'(m_tov));
            checkOutput("model ocf",   int'(bus.ocf),   int'(m_ocf));
            checkOutput("model presc", int'(bus.presc), m_presc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] cs, input logic psr, input logic wr,
                                 input logic [7:0] wdata, input logic [7:0] ocr,
                                 input logic [1:0] fclr, input int cycles);
        bus.cs         = cs;
        bus.psr_clr    = psr;
        bus.tcnt_wr    = wr;
        bus.tcnt_wdata = wdata;
        bus.ocr        = ocr;
        bus.flag_clr   = fclr;
        step(cycles);
    endtask

    task automatic waitPresc(input int target);
        int guard = 0;
        while (m_presc != target && guard < 2100) begin
            step(1);
            guard++;
        end
        if (m_presc != target) begin
            total_cnt++;
            bad_cnt++;
            $display("[TB] FAIL presc wait: got %0d want %0d", m_presc, target);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.t0_pin  = 1'b0;
        applyStimulus(3'd1, 1'b0, 1'b0, 8'd0, 8'd5, 2'b00, 3);
        checkOutput("reset tcnt",  int'(bus.tcnt),  0);
        checkOutput("reset tick",  int'(bus.tick),  0);
        checkOutput("reset tov",   int'(bus.tov),   0);
        checkOutput("reset ocf",   int'(bus.ocf),   0);
        checkOutput("reset presc", int'(bus.presc), 0);

        $display("[TB] clk/1 free run, ocr=5");
        rst_n = 1'b1;
        step(5);
        checkOutput("t1 tcnt at 5th tick", int'(bus.tcnt), 5);
        checkOutput("t1 ocf at 5th tick",  int'(bus.ocf),  1);
        checkOutput("t1 tick",             int'(bus.tick), 1);
        step(251);
        checkOutput("t1 tcnt wrap",  int'(bus.tcnt),  0);
        checkOutput("t1 tov wrap",   int'(bus.tov),   1);
        checkOutput("t1 presc 256",  int'(bus.presc), 256);
        step(44);
        applyStimulus(3'd1, 1'b0, 1'b0, 8'd0, 8'hFF, 2'b11, 1);
        checkOutput("flags cleared tov", int'(bus.tov), 0);
        checkOutput("flags cleared ocf", int'(bus.ocf), 0);

        $display("[TB] write collides with count, blocked compare, flag clear race");
        applyStimulus(3'd1, 1'b0, 1'b1, 8'hFE, 8'hFF, 2'b00, 1);
        checkOutput("t4 tcnt written", int'(bus.tcnt), 8'hFE);
        checkOutput("t4 tick dropped", int'(bus.tick), 0);
        applyStimulus(3'd1, 1'b0, 1'b0, 8'h00, 8'hFF, 2'b00, 1);
        checkOutput("t4 tcnt FF",      int'(bus.tcnt), 8'hFF);
        checkOutput("t4 ocf blocked",  int'(bus.ocf),  0);
        applyStimulus(3'd1, 1'b0, 1'b0, 8'h00, 8'hFF, 2'b01, 1);
        checkOutput("t5 tcnt 00",          int'(bus.tcnt), 0);
        checkOutput("t5 tov set beats clr", int'(bus.tov), 1);
        step(1);
        checkOutput("t5 tov cleared", int'(bus.tov), 0);

        $display("[TB] ocr=0 matches on wrap");
        applyStimulus(3'd1, 1'b0, 1'b1, 8'hFD, 8'h00, 2'b00, 1);
        applyStimulus(3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 3);
        checkOutput("ocr0 tcnt", int'(bus.tcnt), 0);
        checkOutput("ocr0 ocf",  int'(bus.ocf),  1);
        applyStimulus(3'd5, 1'b0, 1'b0, 8'h00, 8'h80, 2'b11, 1);

        $display("[TB] clk/1024 with prescaler clear landing on 1023");
        waitPresc(1023);
        applyStimulus(3'd5, 1'b1, 1'b0, 8'h00, 8'h80, 2'b00, 1);
        checkOutput("t2 no tick at cleared 1023", int'(bus.tick),  0);
        checkOutput("t2 presc cleared",           int'(bus.presc), 0);
        applyStimulus(3'd5, 1'b0, 1'b0, 8'h00, 8'h80, 2'b00, 1023);
        checkOutput("t2 no tick before 1024", int'(bus.tick), 0);
        step(1);
        checkOutput("t2 tick after 1024", int'(bus.tick), 1);

        $display("[TB] external T0 rising then falling edges");
        applyStimulus(3'd7, 1'b0, 1'b1, 8'h00, 8'h80, 2'b00, 1);
        applyStimulus(3'd7, 1'b0, 1'b0, 8'h00, 8'h80, 2'b00, 1);
        bus.t0_pin = 1'b1;
        step(2);
        checkOutput("t3 no tick 2 clks after edge", int'(bus.tick), 0);
        step(1);
        checkOutput("t3 tick 3 clks after edge", int'(bus.tick), 1);
        step(4);
        for (int i = 1; i < 10; i++) begin
            bus.t0_pin = ~bus.t0_pin;
            step(7);
        end
        checkOutput("t3 rising count", int'(bus.tcnt), 5);
        bus.cs = 3'd6;
        for (int i = 0; i < 10; i++) begin
            bus.t0_pin = ~bus.t0_pin;
            step(7);
        end
        checkOutput("t3 falling count", int'(bus.tcnt), 10);

        $display("[TB] cs change at presc=63 then reset");
        applyStimulus(3'd3, 1'b0, 1'b0, 8'h00, 8'h80, 2'b00, 1);
        waitPresc(63);
        applyStimulus(3'd4, 1'b0, 1'b0, 8'h00, 8'h80, 2'b00, 1);
        checkOutput("t6 no tick with new cs", int'(bus.tick), 0);
        rst_n = 1'b0;
        step(1);
        checkOutput("t6 reset tcnt",  int'(bus.tcnt),  0);
        checkOutput("t6 reset presc", int'(bus.presc), 0);
        checkOutput("t6 reset tov",   int'(bus.tov),   0);
        rst_n = 1'b1;
        step(1);
        checkOutput("t6 presc restarts", int'(bus.presc), 1);
        step(5);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
